// File: rtl/seq_mult.sv
// Iterative shift-add multiplier, WIDTH x WIDTH -> 2*WIDTH, one multiplier bit per clock.
// Define SEQ_MULT_EARLY_EXIT_EN to finish as soon as the remaining multiplier bits are all zero.
module seq_mult #(
  parameter int WIDTH = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic               is_signed,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] p,
  output logic               busy
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t               state_q, state_d;
  logic                 neg_q, neg_d;
  logic [2*WIDTH-1:0]   mcand_q, mcand_d;
  logic [2*WIDTH-1:0]   acc_q, acc_d;
  logic [2*WIDTH-1:0]   p_q, p_d;
  logic [WIDTH-1:0]     mplier_q, mplier_d;
  logic [CW-1:0]        count_q, count_d;

  logic [WIDTH-1:0]     a_mag, b_mag;
  logic [2*WIDTH-1:0]   acc_sum;
  logic                 run_last;

  // Negating the most negative value wraps to 2^(WIDTH-1), which is exactly the unsigned magnitude.
  always_comb begin
    a_mag = (is_signed && a[WIDTH-1]) ? -a : a;
    b_mag = (is_signed && b[WIDTH-1]) ? -b : b;
  end

  always_comb begin
    state_d  = state_q;
    neg_d    = neg_q;
    mcand_d  = mcand_q;
    acc_d    = acc_q;
    p_d      = p_q;
    mplier_d = mplier_q;
    count_d  = count_q;
    run_last = 1'b0;
    acc_sum  = mplier_q[0] ? (acc_q + mcand_q) : acc_q;

    case (state_q)
      IDLE: begin
        if (in_valid) begin
          state_d  = RUN;
          neg_d    = is_signed & (a[WIDTH-1] ^ b[WIDTH-1]);
          mcand_d  = {{WIDTH{1'b0}}, a_mag};
          mplier_d = b_mag;
          acc_d    = '0;
          count_d  = CW'(WIDTH);
        end
      end
      RUN: begin
        acc_d    = acc_sum;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        count_d  = count_q - CW'(1);
`ifdef SEQ_MULT_EARLY_EXIT_EN
        run_last = (count_d == '0) || (mplier_d == '0);
`else
        run_last = (count_d == '0);
`endif
        // The product uses this edge's sum so the final partial product is included.
        if (run_last) begin
          state_d = DONE;
          p_d     = neg_q ? -acc_sum : acc_sum;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      neg_q    <= 1'b0;
      mcand_q  <= '0;
      acc_q    <= '0;
      p_q      <= '0;
      mplier_q <= '0;
      count_q  <= '0;
    end else begin
      state_q  <= state_d;
      neg_q    <= neg_d;
      mcand_q  <= mcand_d;
      acc_q    <= acc_d;
      p_q      <= p_d;
      mplier_q <= mplier_d;
      count_q  <= count_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q != IDLE);
  assign p         = p_q;

endmodule

// File: tb/tb_seq_mult.sv
// Scoreboard bench for seq_mult at WIDTH=8; latency expectations follow SEQ_MULT_EARLY_EXIT_EN.
module tb_seq_mult;
  localparam int W = 8;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           in_valid = 1'b0;
  logic           in_ready;
  logic [W-1:0]   a = '0;
  logic [W-1:0]   b = '0;
  logic           is_signed = 1'b0;
  logic           out_valid;
  logic           out_ready = 1'b1;
  logic [2*W-1:0] p;
  logic           busy;

  seq_mult #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .is_signed(is_signed), .out_valid(out_valid),
    .out_ready(out_ready), .p(p), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2*W-1:0] p;
    int             acc_cyc;
    int             lat;
  } exp_t;

  exp_t           q[$];
  exp_t           cur;
  int             nchk = 0;
  int             nfail = 0;
  int             cyc = 0;
  int             acc_count = 0;
  int             last_acc_cyc = 0;
  int             hs_cyc = 0;
  logic           in_flight = 1'b0;
  logic           prev_ov = 1'b0;
  logic [2*W-1:0] last_p = '0;

  function automatic logic [2*W-1:0] model_p(logic [W-1:0] x, logic [W-1:0] y, logic s);
    longint xs, ys;
    logic [63:0] r;
    xs = s ? longint'($signed(x)) : longint'(x);
    ys = s ? longint'($signed(y)) : longint'(y);
    r  = xs * ys;
    return r[2*W-1:0];
  endfunction

  function automatic int exp_lat(logic [W-1:0] y, logic s);
`ifdef SEQ_MULT_EARLY_EXIT_EN
    logic [W-1:0] m;
    int h;
    m = (s && y[W-1]) ? -y : y;
    h = 0;
    for (int i = 0; i < W; i++) if (m[i]) h = i + 1;
    return (h == 0) ? 1 : h;
`else
    return (y === y && s === s) ? W : W;
`endif
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    nchk++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Accept model: an operation is taken on any edge where in_valid is high and nothing is outstanding.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_flight <= 1'b0;
      q.delete();
    end else if (in_valid && !in_flight) begin
      in_flight <= 1'b1;
      q.push_back('{model_p(a, b, is_signed), cyc + 1, exp_lat(b, is_signed)});
      acc_count    <= acc_count + 1;
      last_acc_cyc <= cyc + 1;
      $display("accept a=%0h b=%0h signed=%0d at cycle %0d", a, b, is_signed, cyc + 1);
    end else if (in_flight && out_valid && out_ready) begin
      in_flight <= 1'b0;
      hs_cyc    <= cyc + 1;
    end
  end

  always @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_ov = 1'b0;
      last_p  = '0;
    end else begin
      chk("in_ready", in_ready, !in_flight);
      chk("busy", busy, in_flight);
      if (out_valid && !prev_ov) begin
        if (q.size() == 0) begin
          nchk++;
          nfail++;
          $display("FAIL unexpected_out_valid: got p=%0h with no operation outstanding", p);
        end else begin
          cur = q.pop_front();
          chk("product", p, cur.p);
          chk("latency", cyc - cur.acc_cyc, cur.lat);
          last_p = cur.p;
          $display("result p=%0h expected %0h latency %0d", p, cur.p, cyc - cur.acc_cyc);
        end
      end else begin
        chk("p_hold", p, last_p);
      end
      prev_ov = out_valid;
    end
  end

  task automatic issue(input logic [W-1:0] ai, input logic [W-1:0] bi, input logic si);
    int start, n;
    start     = acc_count;
    a         = ai;
    b         = bi;
    is_signed = si;
    in_valid  = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (acc_count == start && n < 400);
    if (acc_count == start) begin
      nchk++;
      nfail++;
      $display("FAIL accept_timeout: got no accept after %0d cycles, required one", n);
    end
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (in_flight && n < 400) begin
      @(negedge clk);
      n++;
    end
    if (in_flight) begin
      nchk++;
      nfail++;
      $display("FAIL idle_timeout: got busy after %0d cycles, required idle", n);
    end
  endtask

  task automatic one_op(input logic [W-1:0] ai, input logic [W-1:0] bi, input logic si);
    issue(ai, bi, si);
    in_valid = 1'b0;
    wait_idle();
  endtask

  initial begin
    int n, prev_acc;
    logic [W-1:0] pb;
    logic ps, rs;
    logic [W-1:0] ra, rb;

    #1;
    chk("reset_in_ready", in_ready, 1);
    chk("reset_out_valid", out_valid, 0);
    chk("reset_busy", busy, 0);
    chk("reset_p", p, 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Unsigned corner and signed boundary cases.
    one_op(8'hFF, 8'hFF, 1'b0);
    one_op(8'h80, 8'h80, 1'b1);
    one_op(8'h80, 8'h7F, 1'b1);
    one_op(8'hFD, 8'h05, 1'b1);
    one_op(8'h7F, 8'h80, 1'b0);
    one_op(8'hFF, 8'hFF, 1'b1);

    // Back-pressure with new operands waiting on in_valid.
    out_ready = 1'b0;
    issue(8'h12, 8'h34, 1'b0);
    a = 8'h56;
    b = 8'h78;
    n = 0;
    while (!out_valid && n < 400) begin
      @(negedge clk);
      n++;
    end
    for (int i = 0; i < 5; i++) begin
      chk("bp_out_valid", out_valid, 1);
      chk("bp_p", p, 16'h03A8);
      @(negedge clk);
    end
    out_ready = 1'b1;
    issue(8'h56, 8'h78, 1'b0);
    chk("accept_after_handshake", last_acc_cyc, hs_cyc + 1);
    in_valid = 1'b0;
    wait_idle();

    // Reset asserted on the fourth RUN edge aborts the operation.
    issue(8'h0F, 8'h0F, 1'b0);
    in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("abort_out_valid", out_valid, 0);
    chk("abort_p", p, 0);
    chk("abort_in_ready", in_ready, 1);
    chk("abort_busy", busy, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    one_op(8'h03, 8'h07, 1'b0);

    // Short multipliers: latency depends on the early-exit build.
    one_op(8'h34, 8'h00, 1'b0);
    one_op(8'h34, 8'h03, 1'b0);
    one_op(8'hFF, 8'h01, 1'b1);

    // Back-to-back with in_valid and out_ready held high.
    out_ready = 1'b1;
    prev_acc = 0;
    pb = '0;
    ps = 1'b0;
    for (int k = 0; k < 4; k++) begin
      ra = W'($urandom);
      rb = W'($urandom);
      rs = 1'($urandom_range(0, 1));
      issue(ra, rb, rs);
      if (k > 0) chk("b2b_gap", last_acc_cyc - prev_acc, exp_lat(pb, ps) + 2);
      prev_acc = last_acc_cyc;
      pb = rb;
      ps = rs;
    end
    in_valid = 1'b0;
    wait_idle();

    // Random operations with random output back-pressure.
    for (int k = 0; k < 20; k++) begin
      ra = W'($urandom);
      rb = W'($urandom);
      rs = 1'($urandom_range(0, 1));
      out_ready = 1'($urandom_range(0, 1));
      issue(ra, rb, rs);
      in_valid = 1'b0;
      repeat ($urandom_range(W, W + 4)) @(negedge clk);
      out_ready = 1'b1;
      wait_idle();
    end

    repeat (2) @(negedge clk);
    chk("queue_drained", q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got simulation still running, required completion");
    $fatal(1, "global timeout");
  end

endmodule

// File: doc/seq_mult.md
Name: seq_mult

Overview:
- Parametrised iterative shift-add multiplier: WIDTH x WIDTH -> 2*WIDTH product, one multiplier bit retired per clock.
- Signed and unsigned operands, selected per operation.
- Valid/ready handshakes on input and output sides.
- Replaces fixed-width combinational multiplier trees in the calculator datapath, where area matters more than latency and operand width varies per build.

Parameters:
- WIDTH, 16, operand width in bits (>= 2); product width is 2*WIDTH.

Ports:
- clk  in  1  system clock, rising-edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  operands a, b, is_signed are valid.
- in_ready  out  1  block can accept an operation.
- a  in  WIDTH  multiplicand.
- b  in  WIDTH  multiplier.
- is_signed  in  1  1 = two's-complement operands; 0 = unsigned.
- out_valid  out  1  p holds a completed product.
- out_ready  in  1  consumer accepts p.
- p  out  2*WIDTH  product.
- busy  out  1  operation accepted and not yet consumed; high in RUN or DONE.

Behaviour:
- Reset (rst_n low, asynchronous):
  - State = IDLE; in_ready = 1; out_valid = 0; busy = 0; p = 0.
  - All internal registers are cleared.
  - Reset asserted mid-operation aborts that operation; no output is produced for it.
- FSM states: IDLE, RUN, DONE.
  - in_ready = (state == IDLE).
  - out_valid = (state == DONE).
  - busy = (state != IDLE).
- IDLE: on an edge with in_valid & in_ready, capture the operands and go to RUN:
  - neg = is_signed & (a[MSB] ^ b[MSB]).
  - mcand = |a| zero-extended to 2*WIDTH.
  - mplier = |b|.
  - acc = 0.
  - count = WIDTH.
  - |x| is the two's-complement magnitude when is_signed = 1; otherwise x unchanged.
  - |-2^(WIDTH-1)| = 2^(WIDTH-1) as an unsigned WIDTH-bit value; this case must be exact.
- RUN, each edge:
  - if mplier[0], acc += mcand.
  - mcand <<= 1; mplier >>= 1; count -= 1.
  - When count reaches 0, go to DONE.
- Entering DONE: p = neg ? -acc : acc, modulo 2^(2*WIDTH).
  - p is held stable until the output handshake completes.
- DONE: on an edge with out_ready, go to IDLE. out_valid drops on that edge.
  - No new operation is accepted on the same edge; in_ready is already 0 in DONE.
- Latency: exactly WIDTH clock edges from the accept edge to out_valid high.
  - Throughput: one operation per WIDTH+2 cycles, given out_ready is held high.
- Input changes while not in IDLE are ignored, since operands are captured on accept.
- in_valid may be asserted at any time; it is only sampled in IDLE.
- Back-pressure: out_ready low holds DONE indefinitely, with p stable.
- Arithmetic rules:
  - Unsigned result is exact over [0, (2^WIDTH - 1)^2].
  - Signed result is exact two's complement over the full range, including (-2^(WIDTH-1))^2 = 2^(2*WIDTH-2).
- p retains its last value in IDLE. It is not cleared after handshake.

Optional Feature:
- Macro: SEQ_MULT_EARLY_EXIT_EN.
- Defined: in RUN, if the post-shift mplier == 0, go to DONE on that edge regardless of count.
  - Latency = max(1, index of the highest set bit of |b| + 1) edges.
  - b = 0 therefore completes in 1 edge.
- Undefined: fixed WIDTH-edge latency, as above.
- Product values are identical in both builds.

Test Plan:
- WIDTH=8, unsigned, a=0xFF, b=0xFF, out_ready=1 -> out_valid rises exactly 8 edges after accept; p=0xFE01; in_ready is 0 throughout.
- WIDTH=8, signed, a=0x80 (-128), b=0x80 -> p=0x4000. Then a=0x80, b=0x7F -> p=0xC080 (-16256). Then a=0xFD (-3), b=0x05 -> p=0xFFF1.
- WIDTH=8, unsigned, a=0x12, b=0x34, out_ready held 0 for 5 cycles after out_valid -> p=0x03A8 stable and out_valid high all 5 cycles. in_valid held high with new operands -> not accepted until one cycle after out_ready=1 completes the handshake.
- Reset mid-operation: accept a=0x0F, b=0x0F, pulse rst_n low at the 4th RUN edge -> out_valid=0, p=0, in_ready=1 immediately. Next op a=3, b=7 -> p=0x0015 with full latency.
- With SEQ_MULT_EARLY_EXIT_EN, WIDTH=16:
  - b=0x0000 -> out_valid after 1 edge, p=0.
  - b=0x0003, a=0x1234 -> out_valid after 2 edges, p=0x0000369C.
  - Without the macro -> both cases take 16 edges with the same p.
- Back-to-back: 4 random signed/unsigned operations with in_valid and out_ready held high -> each accept exactly WIDTH+2 cycles apart; all products match the reference model.
